// File: rtl/dds_pkg.sv
// Shared constants, quadrant encoding and pipeline tag type for the DDS ROM arbiter.
// Quadrant fields exist only when DDS_ROM_QUARTER_EN is defined.
package dds_pkg;

    localparam int DDS_ADDR_W  = 10;
    localparam int DDS_DATA_W  = 8;
    localparam int DDS_NUM_REQ = 4;
    // Tag index is sized for the largest supported channel count (8).
    localparam int DDS_IDX_W   = 3;

    typedef logic [1:0] quad_t;

    localparam quad_t QUAD_0 = 2'd0;
    localparam quad_t QUAD_1 = 2'd1;
    localparam quad_t QUAD_2 = 2'd2;
    localparam quad_t QUAD_3 = 2'd3;

    typedef struct packed {
        logic                 valid;
        logic [DDS_IDX_W-1:0] index;
`ifdef DDS_ROM_QUARTER_EN
        quad_t                quadrant;
`endif
    } tag_t;

`ifdef DDS_ROM_QUARTER_EN
    // Quadrants 1 and 3 walk the quarter table backwards.
    function automatic logic mirror_quadrant(input quad_t q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    // Cosine is negative in quadrants 1 and 2.
    function automatic logic negate_quadrant(input quad_t q);
        return (q == QUAD_1) || (q == QUAD_2);
    endfunction
`endif

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin arbiter: searches req starting one past the last winner,
// emits a one-hot grant plus its binary index, and keeps the pointer.
module rr_arbiter_core #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    logic [IDX_W-1:0] pointer;

    always_comb begin : search
        int               sum;
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the search so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        gnt   = '0;
        index = '0;
        valid = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = int'(pointer) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                index     = cand;
            end
        end
        if (rst) begin
            gnt   = '0;
            index = '0;
            valid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer <= IDX_W'(NUM_REQ - 1);
        end else if (valid) begin
            pointer <= index;
        end
    end

endmodule

// File: rtl/dds_rom_arbiter.sv
// Shares one synchronous cosine ROM among NUM_REQ NCO channels with a
// 2-cycle tagged return path. Optional quarter-wave folding: DDS_ROM_QUARTER_EN.
module dds_rom_arbiter
    import dds_pkg::*;
#(
    parameter int NUM_REQ = DDS_NUM_REQ,
    parameter int ADDR_W  = DDS_ADDR_W,
    parameter int DATA_W  = DDS_DATA_W,
`ifdef DDS_ROM_QUARTER_EN
    parameter int ROM_ADDR_W = ADDR_W - 2
`else
    parameter int ROM_ADDR_W = ADDR_W
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ROM_ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]         rom_dout,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        rd_valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [ADDR_W-1:0]     sel_addr;
    logic [ROM_ADDR_W-1:0] folded_addr;
    logic [ROM_ADDR_W-1:0] rom_addr_q;
    tag_t                  tag_d;
    tag_t                  tag_q;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .index (grant_idx),
        .valid (grant_valid)
    );

    assign sel_addr = addr_in[grant_idx*ADDR_W +: ADDR_W];

`ifdef DDS_ROM_QUARTER_EN
    quad_t sel_quad;

    assign sel_quad    = sel_addr[ADDR_W-1 -: 2];
    assign folded_addr = mirror_quadrant(sel_quad) ? ~sel_addr[ROM_ADDR_W-1:0]
                                                   :  sel_addr[ROM_ADDR_W-1:0];
`else
    assign folded_addr = sel_addr;
`endif

    // Idle cycles re-present the previous address so the ROM input stays quiet.
    assign rom_addr = grant_valid ? folded_addr : rom_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= '0;
        end else if (grant_valid) begin
            rom_addr_q <= folded_addr;
        end
    end

    always_comb begin
        tag_d          = '0;
        tag_d.valid    = grant_valid;
        tag_d.index    = DDS_IDX_W'(grant_idx);
`ifdef DDS_ROM_QUARTER_EN
        tag_d.quadrant = sel_quad;
`endif
    end

    // Stage 1: tag travels alongside the ROM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Stage 2: register the ROM word and pulse the owning channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
`ifdef DDS_ROM_QUARTER_EN
            rd_data  <= negate_quadrant(tag_q.quadrant) ? -rom_dout : rom_dout;
`else
            rd_data  <= rom_dout;
`endif
            rd_valid <= tag_q.valid ? (NUM_REQ'(1) << tag_q.index) : '0;
        end
    end

endmodule

// File: tb/tb_dds_rom_arbiter.sv
// Self-checking bench for dds_rom_arbiter: table-driven arbitration/return
// vectors plus hand-written reset and quarter-wave sequences.
module tb_dds_rom_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 10;
    localparam int DW  = 8;
`ifdef DDS_ROM_QUARTER_EN
    localparam int RAW = AW - 2;
`else
    localparam int RAW = AW;
`endif

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] addr_in;
    logic [NR-1:0]    gnt;
    logic [RAW-1:0]   rom_addr;
    logic [DW-1:0]    rom_dout;
    logic [DW-1:0]    rd_data;
    logic [NR-1:0]    rd_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    dds_rom_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr_in  (addr_in),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: rom[a] = a mod 128, one-cycle synchronous read.
    always @(posedge clk) begin
        rom_dout <= {1'b0, rom_addr[6:0]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*AW-1:0] addr;
        logic [NR-1:0]    gnt;
        logic [AW-1:0]    rom;
        logic [NR-1:0]    rv;
        logic [DW-1:0]    rd;
    } vec_t;

    function automatic vec_t mk(input logic [NR-1:0] r, input logic [NR*AW-1:0] a,
                                input logic [NR-1:0] g, input logic [AW-1:0] ra,
                                input logic [NR-1:0] v, input logic [DW-1:0] d);
        vec_t t;
        t.req  = r;
        t.addr = a;
        t.gnt  = g;
        t.rom  = ra;
        t.rv   = v;
        t.rd   = d;
        return t;
    endfunction

    task automatic check_cycle(input string tag, input logic [NR-1:0] eg,
                               input logic [NR-1:0] ev, input logic [DW-1:0] ed);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_gnt_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'(ev));
        if (ev != '0) begin
            check({tag, "_rd_data"}, 32'(rd_data), 32'(ed));
        end
    endtask

    vec_t vecs[16];

    initial begin
        logic [NR*AW-1:0] a_base;
        logic [NR*AW-1:0] a_five;
        a_base = {10'd4, 10'd3, 10'd2, 10'd1};
        a_five = {10'd4, 10'd3, 10'd2, 10'd5};

        // Fair rotation with all requesting, then idle drain.
        vecs[0]  = mk(4'b1111, a_base, 4'b0001, 10'd1, 4'b0000, 8'd0);
        vecs[1]  = mk(4'b1111, a_base, 4'b0010, 10'd2, 4'b0000, 8'd0);
        vecs[2]  = mk(4'b1111, a_base, 4'b0100, 10'd3, 4'b0001, 8'd1);
        vecs[3]  = mk(4'b1111, a_base, 4'b1000, 10'd4, 4'b0010, 8'd2);
        vecs[4]  = mk(4'b1111, a_base, 4'b0001, 10'd1, 4'b0100, 8'd3);
        vecs[5]  = mk(4'b0000, a_base, 4'b0000, 10'd1, 4'b1000, 8'd4);
        vecs[6]  = mk(4'b0000, a_base, 4'b0000, 10'd1, 4'b0001, 8'd1);
        vecs[7]  = mk(4'b0000, a_base, 4'b0000, 10'd1, 4'b0000, 8'd0);
        // Single channel 0 request at address 5.
        vecs[8]  = mk(4'b0001, a_five, 4'b0001, 10'd5, 4'b0000, 8'd0);
        vecs[9]  = mk(4'b0000, a_five, 4'b0000, 10'd5, 4'b0000, 8'd0);
        vecs[10] = mk(4'b0000, a_five, 4'b0000, 10'd5, 4'b0001, 8'd5);
        // Last grant ch1, then req=1010: ch3 wins before ch1.
        vecs[11] = mk(4'b0010, a_base, 4'b0010, 10'd2, 4'b0000, 8'd0);
        vecs[12] = mk(4'b1010, a_base, 4'b1000, 10'd4, 4'b0000, 8'd0);
        vecs[13] = mk(4'b1010, a_base, 4'b0010, 10'd2, 4'b0010, 8'd2);
        vecs[14] = mk(4'b0000, a_base, 4'b0000, 10'd2, 4'b1000, 8'd4);
        vecs[15] = mk(4'b0000, a_base, 4'b0000, 10'd2, 4'b0010, 8'd2);

        rst     = 1'b1;
        req     = 4'b1111;
        addr_in = a_base;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("reset_gnt", 32'(gnt), 32'd0);
            check("reset_rd_valid", 32'(rd_valid), 32'd0);
            check("reset_rd_data", 32'(rd_data), 32'd0);
            check("reset_rom_addr", 32'(rom_addr), 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst     = 1'b0;
            req     = vecs[i].req;
            addr_in = vecs[i].addr;
            #1;
            check_cycle($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rv, vecs[i].rd);
            check($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].rom));
        end

        // Reset mid-flight: ch2 granted, then a one-cycle reset pulse.
        @(negedge clk);
        req     = 4'b0100;
        addr_in = {10'd4, 10'd3, 10'd2, 10'd1};
        #1;
        check_cycle("rst_c0", 4'b0100, 4'b0000, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        check_cycle("rst_c1", 4'b0000, 4'b0000, 8'd0);
        check("rst_c1_rom_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0101;
        #1;
        check_cycle("rst_c2", 4'b0001, 4'b0000, 8'd0);
        @(negedge clk);
        req = 4'b0100;
        #1;
        check_cycle("rst_c3", 4'b0100, 4'b0000, 8'd0);
        @(negedge clk);
        req = 4'b0000;
        #1;
        check_cycle("rst_c4", 4'b0000, 4'b0001, 8'd1);
        @(negedge clk);
        #1;
        check_cycle("rst_c5", 4'b0000, 4'b0100, 8'd3);

`ifdef DDS_ROM_QUARTER_EN
        // Quarter-wave folding: mirror in q1/q3, negate in q1/q2.
        @(negedge clk);
        req     = 4'b0001;
        addr_in = {10'd4, 10'd3, 10'd2, 10'h1FF};
        #1;
        check_cycle("qtr_c0", 4'b0001, 4'b0000, 8'd0);
        check("qtr_c0_rom_addr", 32'(rom_addr), 32'h00);
        @(negedge clk);
        addr_in = {10'd4, 10'd3, 10'd2, 10'h205};
        #1;
        check_cycle("qtr_c1", 4'b0001, 4'b0000, 8'd0);
        check("qtr_c1_rom_addr", 32'(rom_addr), 32'h05);
        @(negedge clk);
        addr_in = {10'd4, 10'd3, 10'd2, 10'h3FE};
        #1;
        check_cycle("qtr_c2", 4'b0001, 4'b0001, 8'h00);
        check("qtr_c2_rom_addr", 32'(rom_addr), 32'h01);
        @(negedge clk);
        req = 4'b0000;
        #1;
        check_cycle("qtr_c3", 4'b0000, 4'b0001, 8'hFB);
        @(negedge clk);
        #1;
        check_cycle("qtr_c4", 4'b0000, 4'b0001, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
